// File: rtl/seq_divider_8bit_if.sv
// Handshake and result bus for the sequential divider.
// The master drives a divide request; the slave returns status and held results.
interface seq_divider_8bit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_8bit.sv
// Unsigned restoring divider: resolves one quotient bit per clock.
// Results are held in dedicated registers that change only when a divide completes.
module seq_divider_8bit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_divider_8bit_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] r, r_n;
  logic [WIDTH-1:0] q, q_n;
  logic [WIDTH-1:0] d, d_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] quo, quo_n;
  logic [WIDTH-1:0] rem, rem_n;
  logic             dbz, dbz_n;
  logic             busy_q, done_q;

  // Shifted partial remainder needs WIDTH+1 bits; the restored/accepted value always
  // fits in WIDTH bits since it stays below the divisor.
  logic [WIDTH:0] rs, t;

  always_comb begin
    state_n = state;
    r_n     = r;
    q_n     = q;
    d_n     = d;
    cnt_n   = cnt;
    quo_n   = quo;
    rem_n   = rem;
    dbz_n   = dbz;
    rs      = {r, q[WIDTH-1]};
    t       = rs - {1'b0, d};

    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          d_n   = bus.divisor;
          q_n   = bus.dividend;
          r_n   = '0;
          cnt_n = '0;
          if (bus.divisor == '0) begin
            state_n = DONE;
            quo_n   = '1;
            rem_n   = bus.dividend;
            dbz_n   = 1'b1;
          end else begin
            state_n = RUN;
          end
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        // A borrow in the trial subtraction means the divisor did not fit: restore.
        r_n   = t[WIDTH] ? rs[WIDTH-1:0] : t[WIDTH-1:0];
        q_n   = {q[WIDTH-2:0], ~t[WIDTH]};
        cnt_n = cnt + CW'(1);
        if (cnt == LAST) begin
          state_n = DONE;
          quo_n   = q_n;
          rem_n   = r_n;
          dbz_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      r      <= '0;
      q      <= '0;
      d      <= '0;
      cnt    <= '0;
      quo    <= '0;
      rem    <= '0;
      dbz    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      r      <= r_n;
      q      <= q_n;
      d      <= d_n;
      cnt    <= cnt_n;
      quo    <= quo_n;
      rem    <= rem_n;
      dbz    <= dbz_n;
      busy_q <= (state_n == RUN);
      done_q <= (state_n == DONE);
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo;
  assign bus.remainder   = rem;
  assign bus.div_by_zero = dbz;
endmodule
